lif_layer_update: RTL and testbench

- Time-multiplexed leaky integrate-and-fire (LIF) layer.
- Each timestep it updates NUM_NEURONS membrane potentials from per-neuron input currents, one neuron per cycle, and emits a spike vector.
- Directly upstream of the debug mux. Its flattened membrane_potentials and output_spikes buses feed the debug module's membrane-potential and spike inputs.
- Both buses change only on a timestep commit, so the debug tap always sees a consistent snapshot.

---
 rtl/lif_layer_update.sv | 169 ++++++++++++++++
 tb/tb_lif_layer_update.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lif_layer_update.sv
// -----------------------------------------------------------------------------
// lif_layer_update
// Time-multiplexed leaky integrate-and-fire layer. A timestep snapshots the
// per-neuron currents and control values, updates one neuron per enabled
// cycle into shadow registers, then commits all potentials and spikes at once
// so downstream taps always see a consistent snapshot.
//
// Ports:
//   clk                in  clock
//   rst                in  asynchronous active-high reset
//   en                 in  global enable; low holds all state
//   start              in  timestep start pulse (honoured only in IDLE)
//   input_currents     in  signed 8-bit current per neuron, neuron i at [8i+7:8i]
//   threshold          in  unsigned firing threshold
//   leak_shift         in  leak = V >> leak_shift
//   refractory_period  in  timesteps a neuron is held after firing
//   membrane_potentials out committed potentials, same packing as currents
//   output_spikes      out committed spike vector
//   busy               out high in LOAD and UPDATE
//   done               out one-cycle pulse after commit
// -----------------------------------------------------------------------------
module lif_layer_update #(
  parameter int NUM_NEURONS = 10,
  parameter int WIDTH       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [NUM_NEURONS*WIDTH-1:0] input_currents,
  input  logic [WIDTH-1:0]             threshold,
  input  logic [2:0]                   leak_shift,
  input  logic [3:0]                   refractory_period,
  output logic [NUM_NEURONS*WIDTH-1:0] membrane_potentials,
  output logic [NUM_NEURONS-1:0]       output_spikes,
  output logic                         busy,
  output logic                         done
);

  localparam int IDXW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UPDATE = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                         state_q;
  logic [IDXW-1:0]                idx_q;
  logic [WIDTH-1:0]               v_q      [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]         spk_q;
  logic [3:0]                     refcnt_q [NUM_NEURONS];
  logic [WIDTH-1:0]               cur_q    [NUM_NEURONS];
  logic [WIDTH-1:0]               thr_q;
  logic [2:0]                     ls_q;
  logic [3:0]                     rp_q;
  logic [NUM_NEURONS*WIDTH-1:0]   mp_q;
  logic [NUM_NEURONS-1:0]         spikes_q;
  logic                           busy_q;
  logic                           done_q;

  logic [WIDTH-1:0]               v_cur_d;
  logic [WIDTH-1:0]               cur_d;
  logic [WIDTH-1:0]               leaked_d;
  logic signed [WIDTH+1:0]        sum_d;
  logic [WIDTH-1:0]               clamped_d;
  logic                           fire_d;

  // Datapath for the neuron currently addressed by idx_q.
  always_comb begin
    v_cur_d  = v_q[idx_q];
    cur_d    = cur_q[idx_q];
    leaked_d = v_cur_d - (v_cur_d >> ls_q);
    // 10-bit signed add: leaked is zero-extended, current sign-extended.
    sum_d    = $signed({2'b00, leaked_d}) + $signed({{2{cur_d[WIDTH-1]}}, cur_d});
    if (sum_d[WIDTH+1]) begin
      clamped_d = {WIDTH{1'b0}};
    end else if (sum_d[WIDTH]) begin
      clamped_d = {WIDTH{1'b1}};
    end else begin
      clamped_d = sum_d[WIDTH-1:0];
    end
    fire_d = (clamped_d >= thr_q);
  end

  // Timestep FSM, neuron state and committed outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= {IDXW{1'b0}};
      spk_q    <= {NUM_NEURONS{1'b0}};
      thr_q    <= {WIDTH{1'b0}};
      ls_q     <= 3'd0;
      rp_q     <= 4'd0;
      mp_q     <= {(NUM_NEURONS*WIDTH){1'b0}};
      spikes_q <= {NUM_NEURONS{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i]      <= {WIDTH{1'b0}};
        refcnt_q[i] <= 4'd0;
        cur_q[i]    <= {WIDTH{1'b0}};
      end
    end else if (en) begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            cur_q[i] <= input_currents[i*WIDTH +: WIDTH];
          end
          thr_q   <= threshold;
          ls_q    <= leak_shift;
          rp_q    <= refractory_period;
          idx_q   <= {IDXW{1'b0}};
          state_q <= UPDATE;
        end
        UPDATE: begin
          if (refcnt_q[idx_q] != 4'd0) begin
            refcnt_q[idx_q] <= refcnt_q[idx_q] - 4'd1;
            v_q[idx_q]      <= {WIDTH{1'b0}};
            spk_q[idx_q]    <= 1'b0;
          end else if (fire_d) begin
            refcnt_q[idx_q] <= rp_q;
            v_q[idx_q]      <= {WIDTH{1'b0}};
            spk_q[idx_q]    <= 1'b1;
          end else begin
            v_q[idx_q]      <= clamped_d;
            spk_q[idx_q]    <= 1'b0;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= COMMIT;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        COMMIT: begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            mp_q[i*WIDTH +: WIDTH] <= v_q[i];
          end
          spikes_q <= spk_q;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end else begin
      done_q <= 1'b0;
    end
  end

  assign membrane_potentials = mp_q;
  assign output_spikes       = spikes_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_lif_layer_update.sv
// -----------------------------------------------------------------------------
// tb_lif_layer_update
// Randomised and directed timesteps against an arithmetic LIF reference model.
// Stimulus pushes expected commits into queues; a negedge monitor pops and
// compares whenever done is seen, and otherwise checks that outputs hold.
// -----------------------------------------------------------------------------
module tb_lif_layer_update;
  localparam int N = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           start;
  logic [N*8-1:0] input_currents;
  logic [7:0]     threshold;
  logic [2:0]     leak_shift;
  logic [3:0]     refractory_period;
  logic [N*8-1:0] membrane_potentials;
  logic [N-1:0]   output_spikes;
  logic           busy;
  logic           done;

  lif_layer_update #(.NUM_NEURONS(N), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .input_currents(input_currents), .threshold(threshold),
    .leak_shift(leak_shift), .refractory_period(refractory_period),
    .membrane_potentials(membrane_potentials), .output_spikes(output_spikes),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         mv  [N];
  int         mrc [N];
  logic [7:0] cur_a [N];
  int         thr, ls, rp;

  logic [N*8-1:0] exp_pot_q [$];
  logic [N-1:0]   exp_spk_q [$];
  int             exp_cyc_q [$];
  logic [N*8-1:0] prev_pot = '0;
  logic [N-1:0]   prev_spk = '0;

  function automatic void model_step(output logic [N*8-1:0] p, output logic [N-1:0] s);
    int c, leaked, sum;
    for (int i = 0; i < N; i++) begin
      if (mrc[i] > 0) begin
        mrc[i] = mrc[i] - 1;
        mv[i]  = 0;
        s[i]   = 1'b0;
      end else begin
        c = cur_a[i];
        if (c > 127) c = c - 256;
        leaked = mv[i] - (mv[i] >> ls);
        sum = leaked + c;
        if (sum < 0) sum = 0;
        if (sum > 255) sum = 255;
        if (sum >= thr) begin
          s[i]   = 1'b1;
          mv[i]  = 0;
          mrc[i] = rp;
        end else begin
          s[i]  = 1'b0;
          mv[i] = sum;
        end
      end
      p[i*8 +: 8] = mv[i][7:0];
    end
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_all(input logic [7:0] c);
    for (int i = 0; i < N; i++) cur_a[i] = c;
  endtask

  // One timestep: optional 3-cycle en stall starting at loop step stall_at,
  // optional scramble of currents after LOAD, optional start pulse mid-UPDATE.
  task automatic do_step(input int stall_at, input bit scramble, input bit extra_start);
    logic [N*8-1:0] p;
    logic [N-1:0]   s;
    int stalls;
    stalls = (stall_at >= 0) ? 3 : 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) input_currents[i*8 +: 8] = cur_a[i];
    threshold         = thr[7:0];
    leak_shift        = ls[2:0];
    refractory_period = rp[3:0];
    start             = 1'b1;
    model_step(p, s);
    exp_pot_q.push_back(p);
    exp_spk_q.push_back(s);
    exp_cyc_q.push_back(cyc + 1 + N + 2 + stalls);
    for (int k = 1; k <= N + 4 + stalls; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        check("busy_after_start", {127'd0, busy}, 128'd1);
      end
      if (k == 2 && scramble) input_currents = {$urandom, $urandom, $urandom};
      if (k == 3 && extra_start) start = 1'b1;
      if (k == 4) start = 1'b0;
      en = !(stall_at >= 0 && k >= stall_at && k < stall_at + 3);
    end
    en = 1'b1;
  endtask

  // Monitor: compare each commit against the scoreboard, else outputs must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_pot_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
        end else begin
          logic [N*8-1:0] ep;
          logic [N-1:0]   es;
          int             ec;
          ep = exp_pot_q.pop_front();
          es = exp_spk_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("potentials", 128'(membrane_potentials), 128'(ep));
          check("spikes", 128'(output_spikes), 128'(es));
          check("done_cycle", 128'(cyc), 128'(ec));
          check("busy_at_done", {127'd0, busy}, 128'd0);
          prev_pot = ep;
          prev_spk = es;
        end
      end else begin
        check("outputs_hold", 128'({membrane_potentials, output_spikes}),
              128'({prev_pot, prev_spk}));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0;
    input_currents = '0; threshold = 8'd0; leak_shift = 3'd0; refractory_period = 4'd0;
    for (int i = 0; i < N; i++) begin mv[i] = 0; mrc[i] = 0; cur_a[i] = 8'd0; end
    thr = 0; ls = 0; rp = 0;
    @(negedge clk); @(negedge clk);
    check("reset_pot", 128'(membrane_potentials), 128'd0);
    check("reset_spk", 128'(output_spikes), 128'd0);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);
    rst = 1'b0;

    // integrate without leak: 30, 60, 90, then fire
    thr = 100; ls = 0; rp = 0; set_all(8'd30);
    repeat (4) do_step(-1, 1'b0, 1'b0);

    // build V=128, then leak by a quarter twice: 96, 72
    thr = 255; set_all(8'd64);
    repeat (2) do_step(-1, 1'b0, 1'b0);
    ls = 2; set_all(8'd0);
    repeat (2) do_step(-1, 1'b0, 1'b0);

    // threshold 0 fires everyone
    thr = 0; ls = 0;
    do_step(-1, 1'b0, 1'b0);

    // saturation high and low
    thr = 255; set_all(8'd125);
    repeat (2) do_step(-1, 1'b0, 1'b0);
    set_all(8'd10);  do_step(-1, 1'b0, 1'b0);
    set_all(8'd3);   do_step(-1, 1'b0, 1'b0);
    set_all(8'hF6);  do_step(-1, 1'b0, 1'b0);

    // refractory hold for two timesteps then fire again
    thr = 100; rp = 2; set_all(8'd127);
    repeat (5) do_step(-1, 1'b0, 1'b0);

    // handshake: ignored start, 3-cycle stall, input change after LOAD
    rp = 0; thr = 200;
    for (int i = 0; i < N; i++) cur_a[i] = 8'($urandom_range(0, 255));
    do_step(-1, 1'b0, 1'b1);
    do_step(5, 1'b0, 1'b0);
    do_step(-1, 1'b1, 1'b0);

    // randomised timesteps
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) cur_a[i] = 8'($urandom_range(0, 255));
      thr = $urandom_range(0, 255);
      ls  = $urandom_range(0, 7);
      rp  = $urandom_range(0, 3);
      do_step(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 10)) : -1, 1'b0, 1'b0);
    end

    // make sure the committed outputs are nonzero before the reset test
    thr = 255; ls = 0; rp = 0; set_all(8'd50);
    do_step(-1, 1'b0, 1'b0);

    // reset while neuron 4 is being updated; timestep is discarded
    @(negedge clk);
    for (int i = 0; i < N; i++) input_currents[i*8 +: 8] = 8'd20;
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    prev_pot = '0;
    prev_spk = '0;
    for (int i = 0; i < N; i++) begin mv[i] = 0; mrc[i] = 0; end
    #1;
    check("midrun_reset_pot", 128'(membrane_potentials), 128'd0);
    check("midrun_reset_spk", 128'(output_spikes), 128'd0);
    check("midrun_reset_busy", {127'd0, busy}, 128'd0);
    check("midrun_reset_done", {127'd0, done}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_all(8'd40);
    do_step(-1, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("pending_commits", 128'(exp_pot_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
